h80cpu_uart_tx: RTL

UART transmit engine for the h80 I/O subsystem. It accepts bytes from the I/O bus decode logic in `h80cpu_io` through a write strobe and buffers them in a small FIFO. Each byte is sent as an 8N1 frame on `uart_txp`, the board's serial transmit pin. The block runs entirely in the system clock domain. Byte writes must already be synchronous to that clock.

---
 rtl/h80cpu_uart_tx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/h80cpu_uart_tx.sv
// UART transmit engine: byte FIFO feeding an 8N1 serializer on uart_txp.
// Frames are back-to-back when bytes are queued; baud timing restarts per frame.
module h80cpu_uart_tx #(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8,
  localparam int LW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          ovr_clr,
  output logic          full,
  output logic [LW-1:0] level,
  output logic          busy,
  output logic          overrun,
  output logic          uart_txp
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          txp_n;
  logic          pop, push, fifo_ne, baud_last;
  logic          busy_n, ovr_n;
  logic [LW-1:0] level_n;
  logic [PW-1:0] wptr, rptr;
  logic [7:0]    mem [FIFO_DEPTH];

  assign fifo_ne   = (level != '0);
  assign baud_last = (cnt == CW'(DIV - 1));
  assign push      = wr_en && !full;
  assign level_n   = level + LW'(push) - LW'(pop);
  assign busy_n    = (state_n != IDLE) || (level_n != '0);
  // A dropped write beats a simultaneous clear.
  assign ovr_n     = (wr_en && full) || (overrun && !ovr_clr);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    txp_n   = uart_txp;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        txp_n = 1'b1;
        if (fifo_ne) begin
          pop     = 1'b1;
          shreg_n = mem[rptr];
          txp_n   = 1'b0;
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (baud_last) begin
          cnt_n   = '0;
          idx_n   = 3'd0;
          txp_n   = shreg[0];
          state_n = DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            txp_n   = 1'b1;
            state_n = STOP;
          end else begin
            idx_n = idx + 3'd1;
            txp_n = shreg[idx + 3'd1];
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          cnt_n = '0;
          // Next queued byte starts immediately with no idle gap.
          if (fifo_ne) begin
            pop     = 1'b1;
            shreg_n = mem[rptr];
            txp_n   = 1'b0;
            state_n = START;
          end else begin
            txp_n   = 1'b1;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= 3'd0;
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      full     <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      uart_txp <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      level    <= level_n;
      full     <= (level_n == LW'(FIFO_DEPTH));
      busy     <= busy_n;
      overrun  <= ovr_n;
      uart_txp <= txp_n;
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  // Datapath storage
  always_ff @(posedge clk) begin
    shreg <= shreg_n;
    if (push && !reset) mem[wptr] <= wr_data;
  end

endmodule
